i2c_master_ctrl: RTL and testbench

Sequencing FSM for the `i2c_master_dp` byte datapath. It accepts one transaction request and drives the datapath strobes bit-by-bit against the SCL edge pulses from the SCL generator: start, address, data bytes, ACK slots, repeated start, single-byte read and stop. It reports completion and slave NACK to the register front-end.

---
 rtl/i2c_master_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// I2C master sequencer: walks one transaction through start, address,
// data, ACK slots, repeated start, single-byte read and stop.
module i2c_master_ctrl #(
  parameter int DATA_WIDTH = 9,
  parameter int CNT_W      = $clog2(DATA_WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             rw,
  input  logic [CNT_W-1:0] nbytes,
  input  logic             scl,
  input  logic             p_edge,
  input  logic             n_edge,
  input  logic             ack_o,
  output logic             start_bit,
  output logic             stop_bit,
  output logic             send_addr,
  output logic             send_data,
  output logic             read_ack,
  output logic             send_ack,
  output logic             read_data,
  output logic [1:0]       repeated_start,
  output logic             ack_i,
  output logic             busy,
  output logic             done,
  output logic             nack
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_STRT, S_HOLD,
    S_ADDR, S_DATA, S_ACK, S_RS1,
    S_RS2, S_RDATA, S_RNACK, S_STOP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE_B = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] nb_eff;
  logic             rw_q;
  logic             rd_addr;
  logic             p_d;
  logic             bit_last;
  logic             more;

  assign bit_last = (bit_cnt == 4'd8);
  assign more     = (byte_cnt != '0);

  // Clamp the requested write length into 1..DATA_WIDTH
  always_comb begin
    nb_eff = nbytes;
    if (nbytes == '0)
      nb_eff = ONE_B;
    else if (nbytes > MAX_B)
      nb_eff = MAX_B;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next-state decode driven by SCL edge pulses
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (req) state_n = S_START;
      S_START: if (p_edge) state_n = S_STRT;
      S_STRT:  state_n = scl ? S_HOLD : S_START;
      S_HOLD:  if (n_edge) state_n = S_ADDR;
      S_ADDR:  if (n_edge && bit_last) state_n = S_ACK;
      S_DATA:  if (n_edge && bit_last) state_n = S_ACK;
      S_ACK: begin
        if (n_edge) begin
          if (nack)
            state_n = S_STOP;
          else if (rd_addr)
            state_n = S_RDATA;
          else if (more)
            state_n = S_DATA;
          else if (rw_q)
            state_n = S_RS1;
          else
            state_n = S_STOP;
        end
      end
      S_RS1:   if (p_edge) state_n = S_RS2;
      S_RS2:   state_n = S_HOLD;
      S_RDATA: if (p_edge && bit_cnt == 4'd7) state_n = S_RNACK;
      S_RNACK: if (n_edge && bit_cnt != 4'd0) state_n = S_STOP;
      S_STOP:  if (p_edge) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from state, bit counter and edge pulse
  always_comb begin
    start_bit      = 1'b0;
    stop_bit       = 1'b0;
    send_addr      = 1'b0;
    send_data      = 1'b0;
    read_ack       = 1'b0;
    send_ack       = 1'b0;
    read_data      = 1'b0;
    repeated_start = 2'b00;
    ack_i          = 1'b1;
    unique case (state)
      S_STRT:  start_bit = scl;
      S_HOLD:  send_addr = 1'b1;
      S_ADDR: begin
        send_addr = !bit_last;
        send_ack  = bit_last;
      end
      S_DATA: begin
        send_data = !bit_last;
        send_ack  = bit_last;
      end
      S_ACK: begin
        if (!n_edge) begin
          read_ack = 1'b1;
        end else if (nack) begin
          send_ack = 1'b1;
          ack_i    = 1'b0;
        end else if (rd_addr) begin
          send_ack = 1'b1;
        end else if (more) begin
          send_data = 1'b1;
        end else if (rw_q) begin
          send_ack = 1'b1;
        end else begin
          send_ack = 1'b1;
          ack_i    = 1'b0;
        end
      end
      S_RS1:   repeated_start = 2'b01;
      S_RS2:   repeated_start = 2'b11;
      S_RDATA: read_data = 1'b1;
      S_RNACK: begin
        send_ack = 1'b1;
        ack_i    = (bit_cnt == 4'd0);
      end
      S_STOP:  stop_bit = 1'b1;
      default: ;
    endcase
  end

  // Counters, latched request and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 4'd0;
      byte_cnt <= '0;
      rw_q     <= 1'b0;
      rd_addr  <= 1'b0;
      p_d      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      p_d  <= p_edge;
      done <= 1'b0;
      if (state == S_IDLE && req) begin
        rw_q     <= rw;
        byte_cnt <= rw ? ONE_B : nb_eff;
        rd_addr  <= 1'b0;
        bit_cnt  <= 4'd0;
        busy     <= 1'b1;
        nack     <= 1'b0;
      end
      if (state == S_HOLD && n_edge)
        bit_cnt <= 4'd1;
      if ((state == S_ADDR || state == S_DATA) && n_edge)
        bit_cnt <= bit_last ? 4'd0 : bit_cnt + 4'd1;
      if (state == S_ACK) begin
        if (p_d)
          nack <= ack_o;
        if (n_edge && state_n == S_DATA) begin
          bit_cnt  <= 4'd1;
          byte_cnt <= byte_cnt - ONE_B;
        end
      end
      if (state == S_RS2)
        rd_addr <= 1'b1;
      if (state == S_RDATA && p_edge)
        bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
      if (state == S_RNACK && n_edge)
        bit_cnt <= 4'd1;
      if (state == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: random transactions against a
// per-transaction strobe-count model with a modelled slave ACK source.
module tb_i2c_master_ctrl;
  localparam int DW = 9;
  localparam int CW = $clog2(DW+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          rw = 1'b0;
  logic [CW-1:0] nbytes = '0;
  logic          scl = 1'b1;
  logic          p_edge = 1'b0;
  logic          n_edge = 1'b0;
  logic          ack_o = 1'b0;
  logic          start_bit, stop_bit, send_addr, send_data;
  logic          read_ack, send_ack, read_data;
  logic [1:0]    repeated_start;
  logic          ack_i, busy, done, nack;

  typedef struct {
    int nack;
    int addr;
    int data;
    int slots;
    int rs;
    int rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int nack_at = 99;
  int slot = 0;
  logic [1:0] div = 2'd0;
  int cyc = 0;
  int m_addr = 0, m_data = 0, m_slot = 0, m_rs = 0;
  int m_rs01 = 0, m_rd = 0, m_start = 0, stop_pe = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  i2c_master_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw),
    .nbytes(nbytes), .scl(scl), .p_edge(p_edge),
    .n_edge(n_edge), .ack_o(ack_o),
    .start_bit(start_bit), .stop_bit(stop_bit),
    .send_addr(send_addr), .send_data(send_data),
    .read_ack(read_ack), .send_ack(send_ack),
    .read_data(read_data),
    .repeated_start(repeated_start),
    .ack_i(ack_i), .busy(busy), .done(done),
    .nack(nack)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(bit r, int nb, int k);
    exp_t e;
    int n;
    if (r) begin
      e.nack  = (k < 3) ? 1 : 0;
      e.slots = (k < 3) ? k + 1 : 3;
      e.addr  = (k >= 2) ? 16 : 8;
      e.data  = (k >= 1) ? 8 : 0;
      e.rs    = (k >= 2) ? 1 : 0;
      e.rd    = (k >= 3) ? 8 : 0;
    end else begin
      n       = (nb == 0) ? 1 : nb;
      e.nack  = (k <= n) ? 1 : 0;
      e.slots = (k <= n) ? k + 1 : n + 1;
      e.addr  = 8;
      e.data  = 8 * ((k <= n) ? k : n);
      e.rs    = 0;
      e.rd    = 0;
    end
    return e;
  endfunction

  // SCL generator: 8 clk per SCL period, edge pulses with the level change
  initial forever begin
    @(posedge clk);
    if (div == 2'd3) begin
      scl    <= ~scl;
      p_edge <= !scl;
      n_edge <= scl;
    end else begin
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end
    div <= div + 2'd1;
  end

  // Slave + datapath ACK model: registered ACK sampled at slot p_edge
  initial forever begin
    @(posedge clk);
    if (!busy)
      slot <= 0;
    else if (p_edge && read_ack) begin
      ack_o <= (slot == nack_at);
      slot  <= slot + 1;
    end
  end

  // Monitor: count strobes per transaction, compare on done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_addr = 0; m_data = 0; m_slot = 0; m_rs = 0;
        m_rs01 = 0; m_rd = 0; m_start = 0;
        prev_done = 1'b0;
      end else begin
        if (n_edge && send_addr) m_addr++;
        if (n_edge && send_data) m_data++;
        if (p_edge && read_ack) m_slot++;
        if (repeated_start == 2'b11) m_rs++;
        if (repeated_start == 2'b01) m_rs01++;
        if (p_edge && read_data) m_rd++;
        if (start_bit) m_start++;
        if (stop_bit && p_edge) stop_pe = cyc;
        if (done) begin
          chk("done_width", int'(prev_done), 0);
          chk("busy_at_done", int'(busy), 0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("nack", int'(nack), e.nack);
            chk("addr_bits", m_addr, e.addr);
            chk("data_bits", m_data, e.data);
            chk("ack_slots", m_slot, e.slots);
            chk("rs11_cycles", m_rs, e.rs);
            chk("rs01_seen", int'(m_rs01 > 0), e.rs);
            chk("rd_pedges", m_rd, e.rd);
            chk("start_cycles", m_start, 1);
            chk("done_lat", cyc - stop_pe, 2);
          end
          m_addr = 0; m_data = 0; m_slot = 0; m_rs = 0;
          m_rs01 = 0; m_rd = 0; m_start = 0;
          done_cnt++;
        end
        prev_done = done;
      end
    end
  end

  task automatic check_idle(string tag);
    chk({tag, "_start_bit"}, int'(start_bit), 0);
    chk({tag, "_stop_bit"}, int'(stop_bit), 0);
    chk({tag, "_send_addr"}, int'(send_addr), 0);
    chk({tag, "_send_data"}, int'(send_data), 0);
    chk({tag, "_read_ack"}, int'(read_ack), 0);
    chk({tag, "_send_ack"}, int'(send_ack), 0);
    chk({tag, "_read_data"}, int'(read_data), 0);
    chk({tag, "_rs"}, int'(repeated_start), 0);
    chk({tag, "_ack_i"}, int'(ack_i), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_nack"}, int'(nack), 0);
  endtask

  task automatic wait_done(int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", 0, 1);
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic run(bit r, int nb, int k, bit poke);
    int d0;
    @(negedge clk);
    nack_at = k;
    rw      = r;
    nbytes  = CW'(nb);
    sb.push_back(model(r, nb, k));
    d0  = done_cnt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    if (poke) begin
      repeat (40) @(negedge clk);
      rw     = ~r;
      nbytes = CW'(DW);
      req    = 1'b1;
      @(negedge clk);
      req    = 1'b0;
    end
    wait_done(d0);
  endtask

  initial begin
    int r, nb, k, n, dc0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    run(0, 1, 99, 0);
    run(0, 3, 99, 0);
    run(0, 3, 0, 0);
    run(1, 0, 99, 0);
    run(0, 4, 2, 1);
    run(1, 0, 0, 0);
    run(1, 0, 1, 0);
    run(1, 0, 2, 0);
    run(0, 0, 99, 0);
    run(0, DW, DW, 0);
    run(0, DW, 99, 1);

    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 1));
      nb = int'($urandom_range(0, DW));
      if ($urandom_range(0, 2) == 0)
        k = int'($urandom_range(0, r ? 2 : ((nb == 0) ? 1 : nb)));
      else
        k = 99;
      run(r[0], nb, k, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    nack_at = 99;
    rw      = 1'b0;
    nbytes  = CW'(5);
    sb.push_back(model(0, 5, 99));
    dc0 = done_cnt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (m_data < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit4", int'(m_data >= 4), 1);
    #2 rst = 1'b0;
    #1 check_idle("mid_rst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_done_after_rst", done_cnt, dc0);

    run(0, 2, 99, 0);
    chk("queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
